// File: rtl/resp_packet_tx.sv
// Return-path packet transmitter: buffers one byte response per port, arbitrates
// round-robin and emits 13-bit even-parity packets on a valid/ready link.
module resp_packet_tx #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    input  logic [7:0]       in_type,
    input  logic [31:0]      in_data,
    output logic [12:0]      packet,
    output logic             valid,
    input  logic             ready,
    output logic [CNT_W-1:0] tx_count
);

    logic [3:0] full;
    logic [1:0] type_q [4];
    logic [7:0] data_q [4];
    logic [1:0] rr_ptr;

    logic        can_load;
    logic        grant_found;
    logic [1:0]  grant_idx;
    logic [1:0]  search_idx;
    logic [11:0] grant_body;
    logic [12:0] grant_packet;

    // in_ready depends only on registered state and reset, never on in_valid.
    assign in_ready = {4{rst}} & ~full;
    assign can_load = ~valid | ready;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        search_idx  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            search_idx = rr_ptr + 2'(k);
            if (!grant_found && full[search_idx]) begin
                grant_found = 1'b1;
                grant_idx   = search_idx;
            end
        end
    end

    assign grant_body   = {data_q[grant_idx], type_q[grant_idx], grant_idx};
    assign grant_packet = {^grant_body, grant_body};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full     <= 4'h0;
            rr_ptr   <= 2'd0;
            packet   <= 13'h0;
            valid    <= 1'b0;
            tx_count <= '0;
            for (int i = 0; i < 4; i++) begin
                type_q[i] <= 2'd0;
                data_q[i] <= 8'd0;
            end
        end else begin
            if (valid && ready) begin
                tx_count <= tx_count + CNT_W'(1);
            end

            if (can_load) begin
                if (grant_found) begin
                    packet <= grant_packet;
                    valid  <= 1'b1;
                    rr_ptr <= grant_idx + 2'd1;
                end else begin
                    valid  <= 1'b0;
                end
            end

            // A granted slot has in_ready low, so load and clear never collide.
            for (int i = 0; i < 4; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    full[i]   <= 1'b1;
                    type_q[i] <= in_type[2*i +: 2];
                    data_q[i] <= in_data[8*i +: 8];
                end else if (can_load && grant_found && grant_idx == 2'(i)) begin
                    full[i]   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_resp_packet_tx.sv
// Directed self-checking bench for resp_packet_tx with hand-computed packets.
module tb_resp_packet_tx;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  in_type;
    logic [31:0] in_data;
    logic [12:0] packet;
    logic        valid;
    logic        ready;
    logic [15:0] tx_count;

    int checks = 0;
    int errors = 0;

    resp_packet_tx #(.CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_type  (in_type),
        .in_data  (in_data),
        .packet   (packet),
        .valid    (valid),
        .ready    (ready),
        .tx_count (tx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic [1:0] t, input logic [7:0] d);
        in_valid[port]        = 1'b1;
        in_type[2*port +: 2]  = t;
        in_data[8*port +: 8]  = d;
    endtask

    task automatic send_one(input int port, input logic [1:0] t, input logic [7:0] d,
                            input logic [12:0] exp_pkt, input string tag);
        applyStimulus(port, t, d);
        tick();
        in_valid = 4'h0;
        checkOutput({tag, "_slot_busy"}, 32'(in_ready), 32'(4'hF & ~(4'h1 << port)));
        checkOutput({tag, "_not_yet"}, 32'(valid), 32'd0);
        tick();
        checkOutput({tag, "_valid"}, 32'(valid), 32'd1);
        checkOutput({tag, "_packet"}, 32'(packet), 32'(exp_pkt));
        checkOutput({tag, "_ready_back"}, 32'(in_ready), 32'hF);
        tick();
        checkOutput({tag, "_one_cycle"}, 32'(valid), 32'd0);
    endtask

    initial begin
        logic [12:0] all_exp [4];
        all_exp[0] = 13'h1AA4;
        all_exp[1] = 13'h0BB9;
        all_exp[2] = 13'h1CCE;
        all_exp[3] = 13'h0DD3;

        rst      = 1'b0;
        in_valid = 4'h0;
        in_type  = 8'h0;
        in_data  = 32'h0;
        ready    = 1'b0;

        #1;
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_packet", 32'(packet), 32'd0);
        checkOutput("rst_count", 32'(tx_count), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rel_in_ready", 32'(in_ready), 32'hF);

        tick();
        ready = 1'b1;
        send_one(0, 2'd1, 8'hAA, 13'h1AA4, "p0");
        checkOutput("count_1", 32'(tx_count), 32'd1);
        send_one(1, 2'd2, 8'hBB, 13'h0BB9, "p1");
        send_one(2, 2'd3, 8'hCC, 13'h1CCE, "p2");
        send_one(3, 2'd0, 8'hDD, 13'h0DD3, "p3");
        checkOutput("count_4", 32'(tx_count), 32'd4);

        // All four ports at once, rr_ptr back at 0
        applyStimulus(0, 2'd1, 8'hAA);
        applyStimulus(1, 2'd2, 8'hBB);
        applyStimulus(2, 2'd3, 8'hCC);
        applyStimulus(3, 2'd0, 8'hDD);
        tick();
        in_valid = 4'h0;
        checkOutput("all_full", 32'(in_ready), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput($sformatf("all_valid%0d", k), 32'(valid), 32'd1);
            checkOutput($sformatf("all_pkt%0d", k), 32'(packet), 32'(all_exp[k]));
            checkOutput($sformatf("all_rdy%0d", k), 32'(in_ready), 32'((4'h1 << (k + 1)) - 1));
        end
        tick();
        checkOutput("all_done", 32'(valid), 32'd0);
        checkOutput("count_8", 32'(tx_count), 32'd8);

        // Backpressure: port 3 occupies the stage, ports 1 and 2 wait in slots
        ready = 1'b0;
        applyStimulus(3, 2'd0, 8'hDD);
        tick();
        in_valid = 4'h0;
        tick();
        applyStimulus(1, 2'd2, 8'hBB);
        applyStimulus(2, 2'd3, 8'hCC);
        tick();
        in_valid = 4'h0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("bp_valid%0d", k), 32'(valid), 32'd1);
            checkOutput($sformatf("bp_pkt%0d", k), 32'(packet), 32'h0DD3);
            checkOutput($sformatf("bp_rdy%0d", k), 32'(in_ready), 32'h9);
        end
        checkOutput("bp_count", 32'(tx_count), 32'd8);
        ready = 1'b1;
        tick();
        checkOutput("bp_first", 32'(packet), 32'h0BB9);
        checkOutput("bp_first_v", 32'(valid), 32'd1);
        tick();
        checkOutput("bp_second", 32'(packet), 32'h1CCE);
        checkOutput("bp_second_v", 32'(valid), 32'd1);
        tick();
        checkOutput("bp_done", 32'(valid), 32'd0);
        checkOutput("count_11", 32'(tx_count), 32'd11);

        // Round robin: after port 3 is granted, port 0 wins over port 3
        ready = 1'b0;
        applyStimulus(3, 2'd0, 8'hDD);
        tick();
        in_valid = 4'h0;
        tick();
        checkOutput("rr_p3_pkt", 32'(packet), 32'h0DD3);
        applyStimulus(0, 2'd1, 8'hAA);
        applyStimulus(3, 2'd0, 8'hDD);
        tick();
        in_valid = 4'h0;
        checkOutput("rr_both_full", 32'(in_ready), 32'h6);
        ready = 1'b1;
        tick();
        checkOutput("rr_first_p0", 32'(packet), 32'h1AA4);
        tick();
        checkOutput("rr_then_p3", 32'(packet), 32'h0DD3);
        tick();
        checkOutput("rr_done", 32'(valid), 32'd0);
        checkOutput("count_14", 32'(tx_count), 32'd14);

        // Asynchronous reset while a packet is held and a slot is full
        ready = 1'b0;
        applyStimulus(1, 2'd2, 8'hBB);
        applyStimulus(2, 2'd3, 8'hCC);
        tick();
        in_valid = 4'h0;
        tick();
        checkOutput("ar_pre_valid", 32'(valid), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("ar_valid", 32'(valid), 32'd0);
        checkOutput("ar_packet", 32'(packet), 32'd0);
        checkOutput("ar_count", 32'(tx_count), 32'd0);
        checkOutput("ar_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("ar_rel_ready", 32'(in_ready), 32'hF);
        ready = 1'b1;
        tick();
        tick();
        checkOutput("ar_discarded", 32'(valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/resp_packet_tx.md
# resp_packet_tx

Return-path packet transmitter for the router. It takes single-byte responses from the four destination ports, arbitrates among them round-robin and serialises them into 13-bit packets on a valid/ready link back toward the packet source. It is the transmit counterpart of the router's packet-receive path. The block buffers one response per port, adds parity and keeps a count of transmitted packets.

## Interface
Parameters:
- CNT_W, default 16: width of the transmitted-packet counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  4  bit i: port i presents a response.
- in_ready  output  4  bit i: port i holding slot can accept.
- in_type  input  8  bits [2i+1:2i]: 2-bit packet type for port i.
- in_data  input  32  bits [8i+7:8i]: 8-bit payload for port i.
- packet  output  13  outgoing packet.
- valid  output  1  packet is valid.
- ready  input  1  downstream accepts the packet.
- tx_count  output  CNT_W  number of packets transferred.

## Operation
- Packet format:
  - [1:0] = source port index i.
  - [3:2] = type.
  - [11:4] = payload.
  - [12] = even parity, i.e. XOR of [11:0], so the whole 13-bit word has an even count of ones.
- Per-port holding slot:
  - Each of the 4 slots has a full flag, a type register and a data register.
  - in_ready[i] = rst & ~full[i]. This is combinational from registers, with no bypass.
  - Transfer in: in_valid[i] & in_ready[i] at posedge loads the slot and sets full[i].
- Output stage: registers packet and valid.
  - The stage can load when ~valid | ready.
  - When it can load and any slot is full, it grants the first full slot searching upward from rr_ptr, modulo 4.
  - On a grant:
    - The stage loads the formatted packet and sets valid = 1.
    - full[grant] is cleared.
    - rr_ptr becomes (grant+1) mod 4.
  - When it can load and no slot is full, valid goes to 0. packet keeps its last value.
- Handshake: a transfer happens when valid & ready at posedge. While valid & ~ready, packet and valid hold stable.
- Counter: tx_count increments on every valid & ready transfer and wraps from all-ones to 0.
- Arbitration states are implicit in rr_ptr (values 0..3). rr_ptr only changes on a grant.

## Timing
- Reset (rst low, asynchronous): every slot empty, valid = 0, packet = 0, rr_ptr = 0, tx_count = 0, in_ready = 4'h0.
- After rst rises, in_ready = 4'hF.
- Latency:
  - A response accepted at edge N appears on packet/valid after edge N+1, provided the output stage is free and no other port is granted.
  - in_ready[i] returns high the cycle after that slot is granted.
- Per-port throughput: at most 1 response every 2 cycles.
- Aggregate throughput: 1 packet per cycle while ready = 1 and slots are full.
- Simultaneous events:
  - A slot granted at edge N cannot be reloaded at edge N, because in_ready was low.
  - Multiple ports filling in the same cycle are all accepted.
  - The output stage can load a new packet in the same cycle the current one transfers (back-to-back).
- Backpressure: with ready = 0 and valid = 1, no grant occurs. All full slots stay full and their in_ready stays low.
- Reset mid-operation: pending slots and any in-flight packet are discarded. tx_count clears.

## Test plan
- Reset then single response: port 0 with type 1, data AA, ready = 1. Required: packet = 13'h1AA4 and valid high for one cycle, 2 cycles after the input, then tx_count = 1.
- Sequential responses from each port, one at a time:
  - port 1, type 2, data BB → 13'h0BB9.
  - port 2, type 3, data CC → 13'h1CCE.
  - port 3, type 0, data DD → 13'h0DD3.
  - Required: tx_count = 4 after the three responses plus the first.
- All four ports load in the same cycle, ready = 1, starting from rr_ptr = 0. Required:
  - Packets from ports 0,1,2,3 on 4 consecutive cycles.
  - in_ready returns high per port, in the same order.
- Backpressure: two ports full, ready = 0 for 5 cycles. Required:
  - packet and valid stable, and in_ready low for both ports.
  - When ready rises, both packets transfer on consecutive cycles with no loss or duplication.
- Round-robin fairness: port 3 is granted, then ports 0 and 3 are both full. Required: port 0 is granted before port 3.
- Asynchronous reset pulse while valid = 1 and slots are full. Required: valid = 0, packet = 0, tx_count = 0 and in_ready = 0 immediately, without waiting for a clock edge. in_ready = 4'hF after release.
